// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: parks the grant on one cache, passes its requests straight through
// and routes in-order read responses back; the grant only moves once no reads are outstanding.
module mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic [31:0] i_icache_addr,
    input  logic        i_icache_ren,
    input  logic        i_icache_wen,
    input  logic [31:0] i_icache_wdata,
    output logic        o_icache_ready,
    output logic [31:0] o_icache_rdata,
    output logic        o_icache_valid,

    input  logic [31:0] i_dcache_addr,
    input  logic        i_dcache_ren,
    input  logic        i_dcache_wen,
    input  logic [31:0] i_dcache_wdata,
    output logic        o_dcache_ready,
    output logic [31:0] o_dcache_rdata,
    output logic        o_dcache_valid,

    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,

    output logic        o_grant,
    output logic        o_err
);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);

    logic            grant_q, grant_d;
    logic [CntW-1:0] count_q, count_d;
    logic            err_q, err_d;

    logic owner_ren;
    logic owner_wen;
    logic full;
    logic cnt_zero;
    logic mem_ren;
    logic ready;
    logic rsp_ok;
    logic rd_acc;

    // Outputs are forced quiet while reset is held; grant_q is already 0 then,
    // so address and write data naturally follow the I-cache.
    always_comb begin
        owner_ren = grant_q ? i_dcache_ren : i_icache_ren;
        owner_wen = grant_q ? i_dcache_wen : i_icache_wen;
        full      = (count_q == CntMax);
        cnt_zero  = (count_q == '0);

        mem_ren     = owner_ren & ~full & ~i_rst;
        o_mem_ren   = mem_ren;
        o_mem_wen   = owner_wen & ~full & ~i_rst;
        o_mem_addr  = grant_q ? i_dcache_addr : i_icache_addr;
        o_mem_wdata = grant_q ? i_dcache_wdata : i_icache_wdata;

        // Ready uses only the registered count, never ren/wen.
        ready          = i_mem_ready & ~full & ~i_rst;
        o_icache_ready = ready & ~grant_q;
        o_dcache_ready = ready & grant_q;

        rsp_ok         = i_mem_valid & ~cnt_zero & ~i_rst;
        o_icache_valid = rsp_ok & ~grant_q;
        o_dcache_valid = rsp_ok & grant_q;
        o_icache_rdata = i_mem_rdata;
        o_dcache_rdata = i_mem_rdata;

        rd_acc = mem_ren & i_mem_ready;
    end

    always_comb begin
        count_d = count_q;
        if (rd_acc && !rsp_ok) begin
            count_d = count_q + CntW'(1);
        end else if (!rd_acc && rsp_ok) begin
            count_d = count_q - CntW'(1);
        end

        // Rotate only when the owner is fully idle and nothing is in flight.
        grant_d = grant_q ^ (~owner_ren & ~owner_wen & cnt_zero & ~i_mem_valid);
        err_d   = err_q | (i_mem_valid & cnt_zero);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant_q <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            grant_q <= grant_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign o_grant = grant_q;
    assign o_err   = err_q;

endmodule
